sha256_msg_ctrl: RTL

SHA256_MSG_CTRL -- requirements
Module: sha256_msg_ctrl

---
 rtl/sha256_pkg.sv | 6 +
 rtl/sha256_msg_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths and message-controller FSM states.
package sha256_pkg;
    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;
    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, OUT} state_t;
endpackage

// File: rtl/sha256_msg_ctrl.sv
// sha256_msg_ctrl: sequences padded blocks of one message into a SHA-256 core,
// counts blocks and holds the final digest until the consumer takes it.
module sha256_msg_ctrl
    import sha256_pkg::*;
#(
    parameter int CTR_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BLOCK_W-1:0]  s_block,
    input  logic                s_last,
    input  logic                abort,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [DIGEST_W-1:0] d_digest,
    output logic [CTR_W-1:0]    d_nblocks,
    output logic                ovf,
    output logic                busy,
    output logic                core_init,
    output logic                core_next,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic                core_ready,
    input  logic                core_digest_valid,
    input  logic [DIGEST_W-1:0] core_digest
);
    state_t state, state_nx;
    logic [CTR_W-1:0] count;
    logic last_r, abort_pend, hs, wait_done, discard, cnt_max, unused_dv;

    assign unused_dv = core_digest_valid;
    assign s_ready   = state == IDLE && !abort;
    assign hs        = s_valid && s_ready;
    assign d_valid   = state == OUT;
    assign core_init = state == ISSUE && count == '0;
    assign core_next = state == ISSUE && count != '0;
    assign busy      = state != IDLE || count != '0;
    assign d_nblocks = count;
    assign cnt_max   = &count;
    assign wait_done = state == WAIT && core_ready;
    // an abort arriving on the exit cycle itself is honoured as well
    assign discard   = abort_pend || abort;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = hs ? ISSUE : IDLE;
            ISSUE:   state_nx = SETTLE;
            SETTLE:  state_nx = WAIT;
            WAIT:    state_nx = core_ready ? ((discard || !last_r) ? IDLE : OUT) : WAIT;
            OUT:     state_nx = (abort || d_ready) ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            ovf        <= 1'b0;
            abort_pend <= 1'b0;
            last_r     <= 1'b0;
            d_digest   <= '0;
            core_block <= '0;
        end else begin
            state <= state_nx;
            if (hs) begin
                core_block <= s_block;
                last_r     <= s_last;
            end
            if (abort && (state == ISSUE || state == SETTLE || state == WAIT))
                abort_pend <= 1'b1;
            if (wait_done) begin
                abort_pend <= 1'b0;
                if (discard) begin
                    count <= '0;
                    ovf   <= 1'b0;
                end else begin
                    count <= cnt_max ? count : count + 1'b1;
                    ovf   <= ovf | cnt_max;
                    if (last_r)
                        d_digest <= core_digest;
                end
            end
            if ((abort && state == IDLE) || (state == OUT && (abort || d_ready))) begin
                count <= '0;
                ovf   <= 1'b0;
            end
        end
    end
endmodule
